// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// pipe_hazard_ctrl : central stall/flush sequencer for the F/D/E/M/W pipeline.
// Optional feature macro: MULTICYCLE_DIV_EN (multi-cycle divide counter).
// Revision: 1.0
// ============================================================================
module pipe_hazard_ctrl #(
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = $clog2(DIV_CYCLES + 1)
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_stall,
  input  logic d_stall,
  input  logic lu_hazard,
  input  logic div_start_e,
  input  logic exc_m,
  output logic stall_f,
  output logic stall_d,
  output logic stall_e,
  output logic stall_m,
  output logic flush_d,
  output logic flush_e,
  output logic flush_m,
  output logic flush_w,
  output logic div_busy,
  output logic div_done,
  output logic div_cancel
);

  localparam logic [1:0] S_RUN       = 2'd0;
  localparam logic [1:0] S_DIV_BUSY  = 2'd1;
  localparam logic [1:0] S_EXC_DRAIN = 2'd2;

  logic [1:0] state_q;
  logic [1:0] state_d;
  logic       exc_take_w;
  logic       div_act_w;
  logic       div_start_w;
  logic       div_last_w;
  logic       div_done_w;
  logic       div_cancel_w;

  // An exception only takes effect when M is not itself waiting on memory.
  assign exc_take_w = exc_m && !d_stall && (state_q != S_EXC_DRAIN);

`ifdef MULTICYCLE_DIV_EN
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             div_done_q;
  logic             div_cancel_q;

  // The div_done cycle still has the finished divide sitting in E, so it must not relaunch.
  assign div_act_w   = (state_q == S_DIV_BUSY) ||
                       ((state_q == S_RUN) && div_start_e && !div_done_q);
  assign div_start_w = (state_q == S_RUN) && div_start_e && !div_done_q && !exc_take_w;
  assign div_last_w  = (state_q == S_DIV_BUSY) && (cnt_q == CNT_W'(1)) && !exc_take_w;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_DIV_BUSY) begin
      cnt_d = exc_take_w ? '0 : (cnt_q - CNT_W'(1));
    end else if (div_start_w) begin
      cnt_d = CNT_W'(DIV_CYCLES - 1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q        <= '0;
      div_done_q   <= 1'b0;
      div_cancel_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      div_done_q   <= div_last_w;
      div_cancel_q <= exc_take_w && (state_q == S_DIV_BUSY);
    end
  end

  assign div_done_w   = div_done_q;
  assign div_cancel_w = div_cancel_q;
  assign div_busy     = (state_q == S_DIV_BUSY) || div_start_w;
`else
  logic unused_div;
  assign unused_div   = ^{div_start_e, 32'(DIV_CYCLES), 32'(CNT_W)};
  assign div_act_w    = 1'b0;
  assign div_start_w  = 1'b0;
  assign div_last_w   = 1'b0;
  assign div_done_w   = 1'b0;
  assign div_cancel_w = 1'b0;
  assign div_busy     = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN: begin
        if (exc_take_w && i_stall) begin
          state_d = S_EXC_DRAIN;
        end else if (div_start_w) begin
          state_d = S_DIV_BUSY;
        end
      end
      S_DIV_BUSY: begin
        if (exc_take_w) begin
          state_d = i_stall ? S_EXC_DRAIN : S_RUN;
        end else if (div_last_w) begin
          state_d = S_RUN;
        end
      end
      S_EXC_DRAIN: begin
        if (!i_stall) begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  // Deepest stalled stage wins: stall it and everything above, bubble the next one.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_m = 1'b0;
    flush_w = 1'b0;
    if (state_q == S_EXC_DRAIN) begin
      stall_f = i_stall;
      flush_d = 1'b1;
    end else if (d_stall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else if (exc_m) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
      flush_m = 1'b1;
      flush_w = 1'b1;
    end else if (div_act_w) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      flush_m = 1'b1;
    end else if (lu_hazard) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end else if (i_stall) begin
      stall_f = 1'b1;
      flush_d = 1'b1;
    end
  end

  assign div_done   = div_done_w;
  assign div_cancel = div_cancel_w;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// tb_pipe_hazard_ctrl : vector table, directed sequences and random stimulus
// against a cycle-level behavioural model. Revision: 1.0
// ============================================================================
module tb_pipe_hazard_ctrl;

  localparam int DIV_CYCLES = 4;
`ifdef MULTICYCLE_DIV_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic i_stall = 1'b0, d_stall = 1'b0, lu_hazard = 1'b0, div_start_e = 1'b0, exc_m = 1'b0;
  logic stall_f, stall_d, stall_e, stall_m;
  logic flush_d, flush_e, flush_m, flush_w;
  logic div_busy, div_done, div_cancel;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.DIV_CYCLES(DIV_CYCLES)) dut (
    .clk(clk), .resetn(resetn),
    .i_stall(i_stall), .d_stall(d_stall), .lu_hazard(lu_hazard),
    .div_start_e(div_start_e), .exc_m(exc_m),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m), .flush_w(flush_w),
    .div_busy(div_busy), .div_done(div_done), .div_cancel(div_cancel)
  );

  // {stall_f,stall_d,stall_e,stall_m, flush_d,flush_e,flush_m,flush_w, busy,done,cancel}
  logic [10:0] outv;
  assign outv = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w,
                 div_busy, div_done, div_cancel};

  int n_chk  = 0;
  int n_pass = 0;
  logic [10:0] obs;

  // Model state: remaining divide-busy cycles after the current one, drain flag, pulses.
  int m_left = 0;
  bit m_drain = 1'b0;
  bit m_done = 1'b0;
  bit m_cancel = 1'b0;

  task automatic chk(input string nm, input logic [10:0] act, input logic [10:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0t: got %b expected %b", nm, $time, act, exp);
  endtask

  function automatic logic [10:0] model_out(input logic is, ds, lu, dv, ex);
    logic [3:0] st;
    logic [3:0] fl;
    logic busy;
    bit act;
    int k;
    st = '0; fl = '0; busy = 1'b0;
    act = EN && (m_left > 0 || (dv && !m_done));
    if (m_drain) begin
      st[0] = is; fl[0] = 1'b1;
    end else if (ds) begin
      st = 4'hF; fl[3] = 1'b1; busy = act;
    end else if (ex) begin
      fl = 4'hF; busy = EN && (m_left > 0);
    end else begin
      k = -1;
      if (is) k = 0;
      if (lu) k = 1;
      if (act) k = 2;
      for (int i = 0; i < 4; i++) if (i <= k) st[i] = 1'b1;
      if (k >= 0) fl[k] = 1'b1;
      busy = act;
    end
    return {st[0], st[1], st[2], st[3], fl[0], fl[1], fl[2], fl[3], busy, m_done, m_cancel};
  endfunction

  task automatic model_update(input logic is, ds, dv, ex);
    bit nd, nc;
    nd = 1'b0; nc = 1'b0;
    if (m_drain) begin
      if (!is) m_drain = 1'b0;
    end else if (ex && !ds) begin
      nc = (m_left > 0);
      m_left = 0;
      if (is) m_drain = 1'b1;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) nd = 1'b1;
    end else if (EN && dv && !m_done) begin
      m_left = DIV_CYCLES - 1;
    end
    m_done = nd;
    m_cancel = nc;
  endtask

  // Called just after a rising edge; leaves the bench just after the next rising edge.
  task automatic step(input logic is, ds, lu, dv, ex, input string nm);
    i_stall = is; d_stall = ds; lu_hazard = lu; div_start_e = dv; exc_m = ex;
    @(negedge clk);
    obs = outv;
    chk(nm, obs, model_out(is, ds, lu, dv, ex));
    @(posedge clk);
    model_update(is, ds, dv, ex);
    #1;
  endtask

  task automatic reset_dut();
    resetn = 1'b0;
    i_stall = 0; d_stall = 0; lu_hazard = 0; div_start_e = 0; exc_m = 0;
    #1;
    chk("reset_outputs", outv, 11'b0);
    m_left = 0; m_drain = 1'b0; m_done = 1'b0; m_cancel = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string      nm;
    logic [4:0] in;   // {i_stall, d_stall, lu_hazard, div_start_e, exc_m}
    logic [10:0] exp;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{"idle",        5'b00000, 11'b0000_0000_000};
    vecs[1]  = '{"istall",      5'b10000, 11'b1000_1000_000};
    vecs[2]  = '{"lu",          5'b00100, 11'b1100_0100_000};
    vecs[3]  = '{"lu_istall",   5'b10100, 11'b1100_0100_000};
    vecs[4]  = '{"div",         5'b00010, EN ? 11'b1110_0010_100 : 11'b0};
    vecs[5]  = '{"div_lu_is",   5'b10110, EN ? 11'b1110_0010_100 : 11'b1100_0100_000};
    vecs[6]  = '{"dstall",      5'b01000, 11'b1111_0001_000};
    vecs[7]  = '{"dstall_exc",  5'b01101, 11'b1111_0001_000};
    vecs[8]  = '{"dstall_div",  5'b01010, EN ? 11'b1111_0001_100 : 11'b1111_0001_000};
    vecs[9]  = '{"exc",         5'b00001, 11'b0000_1111_000};
    vecs[10] = '{"exc_lu_is",   5'b10101, 11'b0000_1111_000};
    vecs[11] = '{"exc_div",     5'b00011, 11'b0000_1111_000};

    for (int v = 0; v < 12; v++) begin
      reset_dut();
      {i_stall, d_stall, lu_hazard, div_start_e, exc_m} = vecs[v].in;
      #1;
      chk(vecs[v].nm, outv, vecs[v].exp);
    end

    // Load-use for a single cycle.
    reset_dut();
    step(0, 0, 1, 0, 0, "lu_seq");
    chk("lu_only", obs, 11'b1100_0100_000);
    step(0, 0, 0, 0, 0, "lu_after");
    chk("lu_cleared", obs, 11'b0);

    // Plain divide: stalls t0..t0+3, done at t0+4 without relaunch.
    for (int t = 0; t < DIV_CYCLES; t++) begin
      step(0, 0, 0, 1, 0, "div_seq");
      chk("div_stall_e", {10'b0, obs[8]}, {10'b0, EN});
    end
    step(0, 0, 0, 1, 0, "div_done_seq");
    chk("div_done_cycle", {8'b0, obs[8], obs[2], obs[1]}, {8'b0, 1'b0, 1'b0, EN});
    step(0, 0, 0, 0, 0, "div_idle");

    // Divide with a data-memory wait in the middle.
    step(0, 0, 0, 1, 0, "div_ds_t0");
    step(0, 1, 0, 1, 0, "div_ds_t1");
    chk("ds_in_div", {7'b0, obs[7], obs[3]}, {7'b0, 1'b1, 1'b1});
    step(0, 1, 0, 1, 0, "div_ds_t2");
    step(0, 0, 0, 1, 0, "div_ds_t3");
    step(0, 0, 0, 1, 0, "div_ds_t4");
    chk("ds_div_done", {10'b0, obs[1]}, {10'b0, EN});
    step(0, 0, 0, 0, 0, "div_ds_idle");

    // Exception kills an in-flight divide.
    step(0, 0, 0, 1, 0, "div_exc_t0");
    step(0, 0, 0, 1, 0, "div_exc_t1");
    step(0, 0, 0, 1, 1, "div_exc_t2");
    chk("exc_flush_all", {3'b0, obs[10:3]}, {3'b0, 8'b0000_1111});
    step(0, 0, 0, 0, 0, "div_exc_t3");
    chk("div_cancel", {10'b0, obs[0]}, {10'b0, EN});
    step(0, 0, 0, 0, 0, "div_exc_t4");
    chk("no_done_after_cancel", {10'b0, obs[1]}, 11'b0);

    // Exception while fetch is outstanding: drain until the fetch returns.
    step(1, 0, 0, 0, 1, "drain_exc");
    for (int t = 0; t < 3; t++) begin
      step(1, 1, 1, 1, 1, "drain_hold");
      chk("drain_hold_out", obs, 11'b1000_1000_000);
    end
    step(0, 0, 1, 0, 0, "drain_last");
    chk("drain_last_out", obs, 11'b0000_1000_000);
    step(0, 0, 1, 0, 0, "after_drain");
    chk("run_after_drain", obs, 11'b1100_0100_000);

    // Reset mid-divide, then a full-length restart.
    step(0, 0, 0, 1, 0, "rst_div_t0");
    step(0, 0, 0, 1, 0, "rst_div_t1");
    reset_dut();
    for (int t = 0; t < DIV_CYCLES; t++) begin
      step(0, 0, 0, 1, 0, "restart_div");
      chk("restart_stall_e", {10'b0, obs[8]}, {10'b0, EN});
    end
    step(0, 0, 0, 1, 0, "restart_done");
    chk("restart_done_out", {10'b0, obs[1]}, {10'b0, EN});
    step(0, 0, 0, 0, 0, "restart_idle");

    // Randomised traffic with occasional asynchronous resets.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        reset_dut();
      end else begin
        step(logic'($urandom_range(0, 3) == 0), logic'($urandom_range(0, 5) == 0),
             logic'($urandom_range(0, 4) == 0), logic'($urandom_range(0, 2) != 0),
             logic'($urandom_range(0, 19) == 0), "rand");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

- Central stall/flush sequencer for the 5-stage (F/D/E/M/W) MIPS pipeline.
- Collects stall causes (instruction-fetch wait, load-use hazard, multi-cycle divide, data-memory wait) and exceptions.
- Drives per-stage `stall_*` (enables of the enable-style pipeline registers) and `flush_*` (synchronous `clear` inputs of the pipeline registers).
- Contains the divide-busy counter and the exception drain state machine.

## Interface
Parameters:
- `DIV_CYCLES`, 32: number of stall cycles a divide holds E; legal range ≥ 2.
- `CNT_W`, `$clog2(DIV_CYCLES+1)`: width of the divide counter.

Ports (clock and reset first):
- `clk`  in  1  single clock, rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `i_stall`  in  1  instruction fetch not yet returned.
- `d_stall`  in  1  data access in M not yet complete.
- `lu_hazard`  in  1  load in E writes a register that D reads.
- `div_start_e`  in  1  E holds a div/divu. Stays high for as long as the instruction sits in E.
- `exc_m`  in  1  exception or eret detected in M.
- `stall_f`, `stall_d`, `stall_e`, `stall_m`  out  1 each  hold the stage register.
- `flush_d`, `flush_e`, `flush_m`, `flush_w`  out  1 each  clear the stage register (insert a bubble).
- `div_busy`  out  1  divide counter active.
- `div_done`  out  1  one-cycle pulse: the divide result is valid and E is released.
- `div_cancel`  out  1  one-cycle pulse: an in-flight divide was killed by an exception.

## Operation
States: RUN, DIV_BUSY, EXC_DRAIN.

General merge rule:
- Let k be the deepest stage stalled by any active source:
  - `i_stall` → F
  - `lu_hazard` → D
  - divide → E
  - `d_stall` → M
- `stall_*` = 1 for every stage ≤ k.
- `flush_*` = 1 for stage k+1 only.
- A stage never has stall and flush high together.

Per-cycle priority:
- `d_stall` = 1:
  - Assert `stall_f`..`stall_m` and `flush_w`.
  - `exc_m` and `lu_hazard` are ignored this cycle.
  - The divide counter keeps counting.
- `exc_m` = 1 (with `d_stall` = 0):
  - Assert `flush_d`, `flush_e`, `flush_m`, `flush_w`; all stalls 0.
  - If in DIV_BUSY: pulse `div_cancel`, clear the counter, go to RUN.
  - If `i_stall` = 1: go to EXC_DRAIN.
- RUN with `div_start_e` = 1 and `div_done` = 0:
  - Load counter = `DIV_CYCLES`-1 and go to DIV_BUSY.
  - This cycle is already a divide-stall cycle.
- DIV_BUSY:
  - Divide source active every cycle; counter decrements every cycle.
  - When counter = 1: go to RUN and register `div_done` = 1 for the next cycle.
- `div_done` cycle:
  - Divide source inactive and `div_start_e` ignored, because the same instruction is still in E.
- EXC_DRAIN:
  - `stall_f` = `i_stall`; `flush_d` = 1; every other output 0; all inputs except `i_stall` ignored.
  - When `i_stall` = 0: `flush_d` = 1 in that cycle (discards the wrong-path fetch), then go to RUN.
- `div_busy` = 1 in DIV_BUSY and in the RUN cycle that starts a divide.

## Timing
- Stall and flush outputs are combinational from inputs and state. No added latency.
- `div_done` and `div_cancel` are registered pulses.
- Divide started at cycle t0 (no exception):
  - `stall_e` = 1 for cycles t0..t0+`DIV_CYCLES`-1.
  - `div_done` = 1 and `stall_e` = 0 at t0+`DIV_CYCLES`.
- Reset (asynchronous, any time, including mid-divide or in EXC_DRAIN):
  - State = RUN, counter = 0, `div_busy` = `div_done` = `div_cancel` = 0.
  - With all inputs 0, every stall and flush output = 0.

## Configuration
- `MULTICYCLE_DIV_EN` defined:
  - Divide counter, DIV_BUSY state and divide outputs exist as above.
- `MULTICYCLE_DIV_EN` undefined:
  - `div_start_e` is ignored and DIV_BUSY is unreachable.
  - `div_busy`, `div_done`, `div_cancel` are tied to 0.
  - The divider is then a single-cycle unit.

## Test plan
- Load-use only, `lu_hazard` = 1 for 1 cycle → `stall_f` = `stall_d` = 1 and `flush_e` = 1 for exactly that cycle; all other outputs 0.
- Divide, `DIV_CYCLES` = 4, `div_start_e` high from t0 → `stall_f`/`stall_d`/`stall_e` and `flush_m` high for t0..t0+3; `div_done` = 1 and stalls 0 at t0+4; no second divide starts at t0+4.
- `d_stall` = 1 at t0+1 through t0+2 during that divide → `stall_m` = `flush_w` = 1 at t0+1 and t0+2; `div_done` still arrives at t0+4.
- `exc_m` at t0+2 during a divide with `i_stall` = 0 → `flush_d`, `flush_e`, `flush_m`, `flush_w` = 1 at t0+2; `div_cancel` = 1 at t0+3; state RUN; no `div_done`.
- `exc_m` with `i_stall` = 1 held for 3 cycles → `flush_d` = 1 for 4 cycles (3 with `stall_f` = 1, then 1 with `stall_f` = 0); back in RUN afterwards.
- `resetn` low mid-divide → all outputs 0 immediately; after release, `div_start_e` = 1 restarts a full `DIV_CYCLES`-cycle count.
